regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file for the RV32 core, replacing the single-write, dual-read register file. It offers NRD combinational read ports and NWR synchronous write ports, with an optional same-cycle write-to-read bypass and a hardwired-zero register 0. Contents are zeroed by a hardware clear sweep after reset or on request, and `ready` gates use. It sits between decode (read ports) and writeback (write ports).

## Interface
- `XLEN`, 32: data width in bits.
- `NREG`, 32: number of registers, power of two ≥ 4; `AW = $clog2(NREG)`.
- `NRD`, 2: number of read ports, 1..4.
- `NWR`, 1: number of write ports, 1..2.
- `BYPASS`, 1: 1 = a read of an address written this cycle returns the incoming write data; 0 = it returns the stored value.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `clear_req`  in  1: one-cycle pulse; zeroes all registers via the sweep.
- `ready`  out  1: registered; 1 = file usable; 0 during a sweep.
- `wr_en`  in  NWR: per-port write enable.
- `wr_addr`  in  NWR*AW: packed write addresses; port k is bits [k*AW +: AW].
- `wr_data`  in  NWR*XLEN: packed write data.
- `rd_addr`  in  NRD*AW: packed read addresses.
- `rd_data`  out  NRD*XLEN: packed read data, combinational.

## Operation
- FSM states: `CLEAR` and `READY`.
- On `rst`: state = CLEAR, sweep counter `cnt` = 0, `ready` = 0.
- CLEAR, each rising edge:
  - reg[cnt] ← 0, then `cnt` += 1.
  - When `cnt` == NREG-1, that edge writes the last register and the state moves to READY; `ready` = 1 from the next cycle.
  - All writes are dropped.
  - All `rd_data` = 0.
  - `clear_req` is ignored.
- READY:
  - For each port k with `wr_en[k]` and `wr_addr[k]` ≠ 0: reg[addr] ← data on the edge.
  - Writes to address 0 are discarded; reg 0 always reads 0.
- Write collision (NWR = 2, same non-zero address, both enabled): port 1 wins, for storage and for bypass.
- Read, per port j:
  - `rd_addr[j]` = 0 → 0.
  - Else if BYPASS = 1 and some enabled write port targets the same address this cycle → that port's data (collision rule applies).
  - Else → stored value.
- `clear_req` in READY:
  - State → CLEAR and `cnt` = 0 on that edge.
  - `ready` drops the following cycle.
  - A write presented on the same edge is dropped; clear wins.
- `rst` asserted mid-sweep restarts the sweep from `cnt` = 0.

## Timing
- Reset values: `ready` = 0; `rd_data` = 0 on all ports; state = CLEAR; `cnt` = 0.
- Sweep length: exactly NREG cycles from the first edge after `rst` deasserts (or from the `clear_req` edge) to `ready` = 1. With NREG = 32 that is 32 cycles.
- Write latency: 1 edge. A read in the next cycle returns the new value.
- Bypass latency: 0 cycles, combinational, when BYPASS = 1.
- Read path: purely combinational from `rd_addr`, `wr_*` and storage.
- No output depends combinationally on `clear_req`.

## Structure
- Shared package `regfile_pkg`:
  - state enum `rf_state_t` {CLEAR, READY};
  - `AW` helper function (clog2);
  - localparam `RF_ZERO_ADDR` = 0.
- Sub-module `regfile_clear_fsm`: owns the state, `cnt`, `ready` and the `clear_req` handling. Outputs `sweep_we` and `sweep_addr` to the storage array.
- Top level `regfile_mp`: storage array, write-port priority mux, per-read-port bypass mux and zero-register logic. Generate loops over NRD and NWR.

## Test plan
- Reset, then hold `rst` = 0 for 31 cycles → `ready` = 0 throughout. At cycle 32 `ready` = 1, and reading every address returns 0.
- READY, NWR = 1: write 0xDEADBEEF to x5, then read x5 on both ports next cycle → both return 0xDEADBEEF. Write 0x1234 to x0 → x0 still reads 0.
- BYPASS = 1: write 0xA5A5A5A5 to x7 while port 0 reads x7 in the same cycle → `rd_data[0]` = 0xA5A5A5A5. With BYPASS = 0, the same stimulus returns the old value 0.
- NWR = 2 collision: port 0 writes 0x11 and port 1 writes 0x22 to x3 in the same cycle → x3 = 0x22 next cycle, and the same-cycle bypass read also returns 0x22.
- After writing x1 = 0xFF, pulse `clear_req` together with a write of 0x99 to x2 → `ready` = 0 for 32 cycles; afterwards x1 = 0 and x2 = 0. A write attempted mid-sweep is dropped.
- Assert `rst` at sweep cycle 10 for 2 cycles → the sweep restarts, and `ready` rises exactly 32 cycles after `rst` deasserts.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port integer register file.
package regfile_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_t;

  localparam int RF_ZERO_ADDR = 0;

  function automatic int rf_aw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback facing bus of the register file: packed write and read ports plus clear/ready.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 1
) ();
  localparam int AW = rf_aw(NREG);

  logic                 clear_req;
  logic                 ready;
  logic [NWR-1:0]       wr_en;
  logic [NWR*AW-1:0]    wr_addr;
  logic [NWR*XLEN-1:0]  wr_data;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;

  modport master (
    output clear_req, wr_en, wr_addr, wr_data, rd_addr,
    input  ready, rd_data
  );

  modport slave (
    input  clear_req, wr_en, wr_addr, wr_data, rd_addr,
    output ready, rd_data
  );
endinterface

// File: rtl/regfile_clear_fsm.sv
// Clear-sweep controller: zeroes one register per cycle after reset or clear_req,
// then holds READY until the next clear request.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int NREG = 32,
  parameter int AW   = rf_aw(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_req_i,
  output logic          ready_o,
  output logic          sweep_we_o,
  output logic [AW-1:0] sweep_addr_o
);

  rf_state_t     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        // the edge that clears the last register also opens the file
        if (cnt_q == AW'(NREG - 1)) begin
          state_d = READY;
          ready_d = 1'b1;
          cnt_d   = '0;
        end
      end
      READY: begin
        if (clear_req_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign ready_o      = ready_q;
  assign sweep_we_o   = (state_q == CLEAR);
  assign sweep_addr_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NWR synchronous write ports, NRD combinational read ports,
// optional write-to-read bypass, hardwired-zero x0, sweep-based clear.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);
  localparam int AW = rf_aw(NREG);

  logic                 ready;
  logic                 sweep_we;
  logic [AW-1:0]        sweep_addr;
  logic [NREG-1:0][XLEN-1:0] mem_q;

  logic [AW-1:0]   wa [NWR];
  logic [XLEN-1:0] wd [NWR];
  logic [NWR-1:0]  wr_hit;

  regfile_clear_fsm #(.NREG(NREG), .AW(AW)) u_fsm (
    .clk          (clk),
    .rst          (rst),
    .clear_req_i  (bus.clear_req),
    .ready_o      (ready),
    .sweep_we_o   (sweep_we),
    .sweep_addr_o (sweep_addr)
  );

  assign bus.ready = ready;

  // a clear request on the same edge as a write wins over the write
  for (genvar k = 0; k < NWR; k++) begin : g_wr
    assign wa[k]     = bus.wr_addr[k*AW +: AW];
    assign wd[k]     = bus.wr_data[k*XLEN +: XLEN];
    assign wr_hit[k] = ready && !bus.clear_req && bus.wr_en[k] &&
                       (wa[k] != AW'(RF_ZERO_ADDR));
  end

  // higher-numbered write ports are applied last so they win a collision
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem_q[sweep_addr] <= '0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (wr_hit[k]) mem_q[wa[k]] <= wd[k];
      end
    end
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;

    assign ra = bus.rd_addr[j*AW +: AW];

    always_comb begin
      rd = '0;
      if (ready && (ra != AW'(RF_ZERO_ADDR))) begin
        rd = mem_q[ra];
        if (BYPASS != 0) begin
          for (int k = 0; k < NWR; k++) begin
            if (bus.wr_en[k] && (wa[k] == ra)) rd = wd[k];
          end
        end
      end
    end

    assign bus.rd_data[j*XLEN +: XLEN] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed plus randomized checks of two register-file configurations against an array model.
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2)) ifa ();
  regfile_mp_if #(.XLEN(32), .NREG(32), .NRD(2), .NWR(1)) ifb ();

  regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave));
  regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave));

  int checks = 0;
  int errors = 0;

  logic [31:0] ma [32];
  logic [31:0] mb [32];
  bit          rdy_m;
  logic        clr;
  logic        en [2];
  logic [4:0]  wa [2];
  logic [31:0] wd [2];
  logic [4:0]  ra [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    ifa.clear_req = clr;
    ifb.clear_req = clr;
    ifa.wr_en     = {en[1], en[0]};
    ifa.wr_addr   = {wa[1], wa[0]};
    ifa.wr_data   = {wd[1], wd[0]};
    ifa.rd_addr   = {ra[1], ra[0]};
    ifb.wr_en     = en[0];
    ifb.wr_addr   = wa[0];
    ifb.wr_data   = wd[0];
    ifb.rd_addr   = {ra[1], ra[0]};
    #1;
  endtask

  // Expected read: x0 and a clearing file read 0; A forwards the last matching write.
  function automatic logic [31:0] exp_rd(input bit is_a, input logic [4:0] addr);
    logic [31:0] v;
    if (!rdy_m || addr == 5'd0) return 32'h0;
    v = is_a ? ma[addr] : mb[addr];
    if (is_a)
      for (int k = 0; k < 2; k++)
        if (en[k] && wa[k] == addr) v = wd[k];
    return v;
  endfunction

  task automatic step();
    drive();
    if (rdy_m && clr) begin
      rdy_m = 0;
      for (int i = 0; i < 32; i++) begin ma[i] = 0; mb[i] = 0; end
    end else if (rdy_m) begin
      for (int k = 0; k < 2; k++)
        if (en[k] && wa[k] != 5'd0) ma[wa[k]] = wd[k];
      if (en[0] && wa[0] != 5'd0) mb[wa[0]] = wd[0];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reads();
    drive();
    for (int j = 0; j < 2; j++) begin
      chk("rd_a", ifa.rd_data[j*32 +: 32], exp_rd(1'b1, ra[j]));
      chk("rd_b", ifb.rd_data[j*32 +: 32], exp_rd(1'b0, ra[j]));
    end
  endtask

  task automatic chk_ready(input string tag, input logic exp);
    chk({tag, "_a"}, {31'b0, ifa.ready}, {31'b0, exp});
    chk({tag, "_b"}, {31'b0, ifb.ready}, {31'b0, exp});
  endtask

  task automatic quiet();
    clr = 0;
    for (int k = 0; k < 2; k++) begin en[k] = 0; wa[k] = 0; wd[k] = 0; ra[k] = 0; end
  endtask

  initial begin
    rst = 1'b1;
    rdy_m = 0;
    quiet();
    for (int i = 0; i < 32; i++) begin ma[i] = 0; mb[i] = 0; end
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk_ready("reset_ready", 1'b0);
    ra[0] = 5; ra[1] = 31;
    chk_reads();

    // Power-up sweep: 31 cycles low, ready on the 32nd edge
    rst = 1'b0;
    for (int c = 1; c <= 31; c++) begin
      step();
      chk_ready("sweep_ready", 1'b0);
    end
    step();
    chk_ready("sweep_done", 1'b1);
    rdy_m = 1;
    for (int a = 0; a < 32; a += 2) begin
      ra[0] = 5'(a); ra[1] = 5'(a + 1);
      chk_reads();
    end

    // Plain write then read on both ports
    quiet();
    en[0] = 1; wa[0] = 5; wd[0] = 32'hDEADBEEF;
    step();
    quiet();
    ra[0] = 5; ra[1] = 5;
    chk_reads();
    chk("x5_p0", ifa.rd_data[31:0], 32'hDEADBEEF);
    chk("x5_p1", ifb.rd_data[63:32], 32'hDEADBEEF);

    // x0 stays zero
    en[0] = 1; wa[0] = 0; wd[0] = 32'h1234; ra[0] = 0; ra[1] = 0;
    step();
    quiet();
    chk_reads();
    chk("x0_zero", ifa.rd_data[31:0], 32'h0);

    // Same-cycle bypass (A) versus stored value (B)
    en[0] = 1; wa[0] = 7; wd[0] = 32'hA5A5A5A5; ra[0] = 7;
    drive();
    chk("bypass_on", ifa.rd_data[31:0], 32'hA5A5A5A5);
    chk("bypass_off", ifb.rd_data[31:0], 32'h0);
    step();

    // Two-port collision on A: port 1 wins
    quiet();
    en[0] = 1; wa[0] = 3; wd[0] = 32'h11;
    en[1] = 1; wa[1] = 3; wd[1] = 32'h22;
    ra[0] = 3; ra[1] = 3;
    drive();
    chk("coll_bypass", ifa.rd_data[31:0], 32'h22);
    step();
    en[0] = 0; en[1] = 0;
    chk_reads();
    chk("coll_store", ifa.rd_data[63:32], 32'h22);

    // Random traffic over a small address window to provoke collisions
    repeat (150) begin
      clr = 0;
      for (int k = 0; k < 2; k++) begin
        en[k] = 1'($urandom_range(0, 1));
        wa[k] = 5'($urandom_range(0, 7));
        wd[k] = $urandom;
        ra[k] = 5'($urandom_range(0, 7));
      end
      chk_reads();
      step();
    end

    // clear_req with a coincident write, then a write mid-sweep
    quiet();
    en[0] = 1; wa[0] = 1; wd[0] = 32'hFF;
    step();
    en[0] = 1; wa[0] = 2; wd[0] = 32'h99; clr = 1;
    step();
    quiet();
    drive();
    chk_ready("clr_ready", 1'b0);
    for (int i = 1; i <= 31; i++) begin
      en[0] = (i == 10); wa[0] = 4; wd[0] = 32'h77; ra[0] = 4; ra[1] = 1;
      chk_reads();
      step();
      chk_ready("clr_ready", 1'b0);
    end
    quiet();
    step();
    chk_ready("clr_done", 1'b1);
    rdy_m = 1;
    ra[0] = 1; ra[1] = 2;
    chk_reads();
    chk("x1_cleared", ifa.rd_data[31:0], 32'h0);
    ra[0] = 4; ra[1] = 3;
    chk_reads();

    // Reset in the middle of a sweep restarts it
    en[0] = 1; wa[0] = 9; wd[0] = 32'h55;
    step();
    quiet();
    clr = 1;
    step();
    clr = 0;
    repeat (10) step();
    rst = 1'b1;
    drive();
    chk_ready("midrst_ready", 1'b0);
    step();
    step();
    rst = 1'b0;
    drive();
    for (int c = 1; c <= 31; c++) begin
      step();
      chk_ready("restart_ready", 1'b0);
    end
    step();
    chk_ready("restart_done", 1'b1);
    rdy_m = 1;
    ra[0] = 9; ra[1] = 5;
    chk_reads();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
